// File: rtl/pll_lock_sequencer_pkg.sv
// Shared types for the team_08 LCD PLL lock sequencer.
// State encoding, default timing constants and the output decode.
package team08_pll_pkg;

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABILIZE,
    RUN,
    FAULT,
    BYP_SETTLE,
    BYPASS
  } pll_state_t;

  localparam int unsigned DEF_RESET_CYCLES  = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT  = 4096;
  localparam int unsigned DEF_STABLE_CYCLES = 256;
  localparam int unsigned DEF_MAX_RETRIES   = 3;
  localparam int unsigned DEF_CNT_W         = 13;

  typedef struct packed {
    logic resetb;
    logic bypass;
    logic sys_rst_n;
    logic clk_ready;
    logic fault;
  } pll_out_t;

  // Outputs are a pure function of the state they are registered with.
  function automatic pll_out_t decode_out(
    input pll_state_t s
  );
    pll_out_t o;
    o = '0;
    unique case (s)
      RESET_PLL:  o = '0;
      WAIT_LOCK:  o.resetb = 1'b1;
      STABILIZE:  o.resetb = 1'b1;
      RUN: begin
        o.resetb    = 1'b1;
        o.sys_rst_n = 1'b1;
        o.clk_ready = 1'b1;
      end
      FAULT:      o.fault = 1'b1;
      BYP_SETTLE: o.bypass = 1'b1;
      BYPASS: begin
        o.bypass    = 1'b1;
        o.sys_rst_n = 1'b1;
        o.clk_ready = 1'b1;
      end
      default:    o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_if.sv
// Control/status bundle between the PLL sequencer and its neighbours.
// master = sequencer side, slave = PLL wrapper / system side.
interface pll_lock_sequencer_if;

  logic       pll_locked;
  logic       bypass_req;
  logic       restart;
  logic       pll_resetb;
  logic       pll_bypass;
  logic       sys_rst_n;
  logic       clk_ready;
  logic       fault;
  logic [1:0] retry_count;

  modport master (
    input  pll_locked,
    input  bypass_req,
    input  restart,
    output pll_resetb,
    output pll_bypass,
    output sys_rst_n,
    output clk_ready,
    output fault,
    output retry_count
  );

  modport slave (
    output pll_locked,
    output bypass_req,
    output restart,
    input  pll_resetb,
    input  pll_bypass,
    input  sys_rst_n,
    input  clk_ready,
    input  fault,
    input  retry_count
  );

endinterface

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer bringing the raw PLL lock pin into clk.
// Clears to 0 so lock is never assumed out of reset.
module pll_lock_sync (
  input  logic clk,
  input  logic nrst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// LCD PLL reset/bypass sequencer in the 12 MHz reference domain.
// Gates the 48 MHz domain reset on a stable, synchronized lock.
module pll_lock_sequencer
  import team08_pll_pkg::*;
#(
  parameter int unsigned RESET_CYCLES  = DEF_RESET_CYCLES,
  parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned MAX_RETRIES   = DEF_MAX_RETRIES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input logic                 clk,
  input logic                 nrst,
  pll_lock_sequencer_if.master bus
);

  localparam logic [CNT_W-1:0] RST_LAST =
    CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST =
    CNT_W'(STABLE_CYCLES - 1);
  localparam logic [1:0] RETRY_MAX =
    2'(MAX_RETRIES);

  pll_state_t       state;
  pll_state_t       nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       retry_q;
  logic [1:0]       retry_nxt;
  pll_out_t         outs;
  logic             lock_s;
  logic             byp_zone;

  pll_lock_sync u_sync (
    .clk  (clk),
    .nrst (nrst),
    .d    (bus.pll_locked),
    .q    (lock_s)
  );

  assign byp_zone = (state == BYP_SETTLE) ||
                    (state == BYPASS);

  always_comb begin
    nxt       = state;
    retry_nxt = retry_q;
    unique case (state)
      RESET_PLL: begin
        if (cnt == RST_LAST) nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          nxt = STABILIZE;
        end else if (cnt == TMO_LAST) begin
          if (retry_q == RETRY_MAX) begin
            nxt = FAULT;
          end else begin
            nxt       = RESET_PLL;
            retry_nxt = retry_q + 2'd1;
          end
        end
      end
      STABILIZE: begin
        // A lock drop is a glitch, not a failed attempt.
        if (!lock_s) begin
          nxt = WAIT_LOCK;
        end else if (cnt == STB_LAST) begin
          nxt       = RUN;
          retry_nxt = 2'd0;
        end
      end
      RUN: begin
        if (!lock_s) nxt = WAIT_LOCK;
      end
      FAULT: begin
        if (bus.restart) begin
          nxt       = RESET_PLL;
          retry_nxt = 2'd0;
        end
      end
      BYP_SETTLE: begin
        if (!bus.bypass_req) begin
          nxt = RESET_PLL;
        end else if (cnt == RST_LAST) begin
          nxt = BYPASS;
        end
      end
      BYPASS: begin
        if (!bus.bypass_req) begin
          nxt       = RESET_PLL;
          retry_nxt = 2'd0;
        end
      end
      default: nxt = RESET_PLL;
    endcase
    // Bypass wins over every other event, including timeouts.
    if (bus.bypass_req && !byp_zone) begin
      nxt       = BYP_SETTLE;
      retry_nxt = retry_q;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= RESET_PLL;
      cnt     <= '0;
      retry_q <= 2'd0;
      outs    <= '0;
    end else begin
      state   <= nxt;
      retry_q <= retry_nxt;
      outs    <= decode_out(nxt);
      if (nxt != state) begin
        cnt <= '0;
      end else if (cnt != '1) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign bus.pll_resetb  = outs.resetb;
  assign bus.pll_bypass  = outs.bypass;
  assign bus.sys_rst_n   = outs.sys_rst_n;
  assign bus.clk_ready   = outs.clk_ready;
  assign bus.fault       = outs.fault;
  assign bus.retry_count = retry_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for the LCD PLL lock sequencer.
// Short timing parameters; expected cycle counts are worked out by hand.
module tb_pll_lock_sequencer;

  logic clk;
  logic nrst;
  int   n_checks;
  int   n_fail;

  pll_lock_sequencer_if bus ();

  pll_lock_sequencer #(
    .RESET_CYCLES  (4),
    .LOCK_TIMEOUT  (32),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (2),
    .CNT_W         (13)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, ".resetb"}, 32'(bus.pll_resetb), 0);
    chk({tag, ".bypass"}, 32'(bus.pll_bypass), 0);
    chk({tag, ".sys_rst_n"}, 32'(bus.sys_rst_n), 0);
    chk({tag, ".clk_ready"}, 32'(bus.clk_ready), 0);
    chk({tag, ".fault"}, 32'(bus.fault), 0);
    chk({tag, ".retry"}, 32'(bus.retry_count), 0);
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    nrst           = 1'b0;
    bus.pll_locked = 1'b0;
    bus.bypass_req = 1'b0;
    bus.restart    = 1'b0;
    tick(2);
    chk_rst("por");

    // nrst mid WAIT_LOCK
    nrst = 1'b1;
    tick(8);
    chk("wl.resetb_hi", 32'(bus.pll_resetb), 1);
    nrst = 1'b0;
    #1;
    chk_rst("async_wl");
    tick(1);
    nrst = 1'b1;

    // scenario 1: lock 10 cycles after release
    chk("s1.rb0", 32'(bus.pll_resetb), 0);
    tick(1);
    chk("s1.rb1", 32'(bus.pll_resetb), 0);
    tick(2);
    chk("s1.rb3", 32'(bus.pll_resetb), 0);
    tick(1);
    chk("s1.rb4", 32'(bus.pll_resetb), 1);
    tick(6);
    bus.pll_locked = 1'b1;
    tick(10);
    chk("s1.sys_pre", 32'(bus.sys_rst_n), 0);
    chk("s1.rdy_pre", 32'(bus.clk_ready), 0);
    tick(1);
    chk("s1.sys", 32'(bus.sys_rst_n), 1);
    chk("s1.rdy", 32'(bus.clk_ready), 1);
    chk("s1.retry", 32'(bus.retry_count), 0);
    chk("s1.byp", 32'(bus.pll_bypass), 0);

    // scenario 3: one-cycle lock drop in RUN
    tick(2);
    bus.pll_locked = 1'b0;
    tick(1);
    bus.pll_locked = 1'b1;
    chk("s3.sys_d1", 32'(bus.sys_rst_n), 1);
    tick(1);
    chk("s3.sys_d2", 32'(bus.sys_rst_n), 1);
    tick(1);
    chk("s3.sys_d3", 32'(bus.sys_rst_n), 0);
    chk("s3.rdy_d3", 32'(bus.clk_ready), 0);
    tick(8);
    chk("s3.sys_d11", 32'(bus.sys_rst_n), 0);
    tick(1);
    chk("s3.sys_d12", 32'(bus.sys_rst_n), 1);

    // scenario 4: glitch at stable-count 5
    bus.pll_locked = 1'b0;
    tick(3);
    bus.pll_locked = 1'b1;
    tick(6);
    bus.pll_locked = 1'b0;
    tick(1);
    bus.pll_locked = 1'b1;
    tick(4);
    chk("s4.sys_nog", 32'(bus.sys_rst_n), 0);
    chk("s4.retry", 32'(bus.retry_count), 0);
    tick(6);
    chk("s4.sys_pre", 32'(bus.sys_rst_n), 0);
    tick(1);
    chk("s4.sys", 32'(bus.sys_rst_n), 1);

    // scenario 5: bypass from RUN and back
    bus.bypass_req = 1'b1;
    tick(1);
    chk("s5.sys_b1", 32'(bus.sys_rst_n), 0);
    chk("s5.byp_b1", 32'(bus.pll_bypass), 1);
    chk("s5.rdy_b1", 32'(bus.clk_ready), 0);
    chk("s5.rb_b1", 32'(bus.pll_resetb), 0);
    tick(3);
    chk("s5.sys_b4", 32'(bus.sys_rst_n), 0);
    tick(1);
    chk("s5.sys_b5", 32'(bus.sys_rst_n), 1);
    chk("s5.rdy_b5", 32'(bus.clk_ready), 1);
    chk("s5.byp_b5", 32'(bus.pll_bypass), 1);
    tick(3);
    bus.bypass_req = 1'b0;
    tick(1);
    chk("s5.byp_off", 32'(bus.pll_bypass), 0);
    chk("s5.sys_off", 32'(bus.sys_rst_n), 0);
    tick(3);
    chk("s5.rb_lo", 32'(bus.pll_resetb), 0);
    tick(1);
    chk("s5.rb_hi", 32'(bus.pll_resetb), 1);
    tick(8);
    chk("s5.sys_pre", 32'(bus.sys_rst_n), 0);
    tick(1);
    chk("s5.sys_run", 32'(bus.sys_rst_n), 1);

    // nrst mid BYPASS
    bus.bypass_req = 1'b1;
    tick(7);
    chk("byp.sys", 32'(bus.sys_rst_n), 1);
    nrst = 1'b0;
    #1;
    chk_rst("async_byp");
    bus.pll_locked = 1'b0;
    bus.bypass_req = 1'b0;
    tick(1);
    nrst = 1'b1;

    // scenario 2: no lock, retries then FAULT
    chk("s2.rb0", 32'(bus.pll_resetb), 0);
    tick(4);
    chk("s2.rb4", 32'(bus.pll_resetb), 1);
    tick(31);
    chk("s2.rb35", 32'(bus.pll_resetb), 1);
    chk("s2.rt35", 32'(bus.retry_count), 0);
    tick(1);
    chk("s2.rb36", 32'(bus.pll_resetb), 0);
    chk("s2.rt36", 32'(bus.retry_count), 1);
    tick(3);
    chk("s2.rb39", 32'(bus.pll_resetb), 0);
    tick(1);
    chk("s2.rb40", 32'(bus.pll_resetb), 1);
    tick(31);
    chk("s2.rt71", 32'(bus.retry_count), 1);
    tick(1);
    chk("s2.rt72", 32'(bus.retry_count), 2);
    chk("s2.rb72", 32'(bus.pll_resetb), 0);
    tick(4);
    chk("s2.rb76", 32'(bus.pll_resetb), 1);
    tick(31);
    chk("s2.flt107", 32'(bus.fault), 0);
    tick(1);
    chk("s2.flt108", 32'(bus.fault), 1);
    chk("s2.rb108", 32'(bus.pll_resetb), 0);
    chk("s2.rt108", 32'(bus.retry_count), 2);
    chk("s2.sys108", 32'(bus.sys_rst_n), 0);
    tick(5);
    chk("s2.flt_hold", 32'(bus.fault), 1);
    bus.pll_locked = 1'b1;
    tick(3);
    chk("s2.flt_lock", 32'(bus.fault), 1);
    bus.restart = 1'b1;
    tick(1);
    bus.restart = 1'b0;
    chk("s2.flt_clr", 32'(bus.fault), 0);
    chk("s2.rt_clr", 32'(bus.retry_count), 0);
    chk("s2.rb_r1", 32'(bus.pll_resetb), 0);
    tick(3);
    chk("s2.rb_r4", 32'(bus.pll_resetb), 0);
    tick(1);
    chk("s2.rb_r5", 32'(bus.pll_resetb), 1);
    tick(8);
    chk("s2.sys_r13", 32'(bus.sys_rst_n), 0);
    tick(1);
    chk("s2.sys_r14", 32'(bus.sys_rst_n), 1);
    chk("s2.rdy_r14", 32'(bus.clk_ready), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
